// File: rtl/csv_tokenizer_pkg.sv
// Shared types and constants for the CSV byte-stream tokenizer.
package csv;

  // Token kinds carried on out_kind.
  typedef enum logic [1:0] {
    TOK_CHAR       = 2'd0,
    TOK_END_FIELD  = 2'd1,
    TOK_END_RECORD = 2'd2
  } token_kind_e;

  // Parser states; exposed on fsm_state for observation.
  typedef enum logic [2:0] {
    FIELD_START = 3'd0,
    UNQUOTED    = 3'd1,
    QUOTED      = 3'd2,
    QUOTE_SEEN  = 3'd3,
    RESYNC      = 3'd4
  } state_e;

  localparam logic [7:0]  CSV_LF            = 8'h0A;
  localparam logic [7:0]  CSV_CR            = 8'h0D;
  localparam logic [7:0]  CSV_DEFAULT_DELIM = 8'h2C;
  localparam logic [7:0]  CSV_DEFAULT_QUOTE = 8'h22;
  localparam logic [15:0] CSV_ERR_MAX       = 16'hFFFF;

endpackage

// File: rtl/csv_tokenizer.sv
// CSV tokenizer: turns a raw byte stream into CHAR / END_FIELD /
// END_RECORD tokens, handling quoted fields and "" escapes.
//
// Handshake: a byte moves on in_valid && in_ready, a token moves on
// out_valid && out_ready. There is one output register, so a new byte
// can be taken whenever that register is empty or being drained in
// the same cycle. Bytes that produce no token are still accepted and
// leave the output register alone. in_ready is also forced high while
// rst_n is low, since the output register is being cleared anyway.
module csv_tokenizer
  import csv::*;
#(
  parameter logic [7:0] DELIM = CSV_DEFAULT_DELIM,
  parameter logic [7:0] QUOTE = CSV_DEFAULT_QUOTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output token_kind_e out_kind,
  output logic [7:0]  out_data,
  output logic        err,
  output logic [15:0] err_count,
  output state_e      fsm_state
);

  state_e      state_q;
  state_e      state_d;
  logic        emit;
  token_kind_e kind_d;
  logic [7:0]  data_d;
  logic        syntax_err;
  logic        accept;

  logic        out_valid_q;
  token_kind_e out_kind_q;
  logic [7:0]  out_data_q;
  logic        err_q;
  logic [15:0] err_count_q;

  assign in_ready  = !rst_n || !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign fsm_state = state_q;

  // Next-state and token decode for the byte currently on in_data.
  always_comb begin
    state_d    = state_q;
    emit       = 1'b0;
    kind_d     = TOK_CHAR;
    data_d     = 8'h00;
    syntax_err = 1'b0;
    case (state_q)
      FIELD_START: begin
        if (in_data == QUOTE) begin
          state_d = QUOTED;
        end else if (in_data == DELIM) begin
          emit   = 1'b1;
          kind_d = TOK_END_FIELD;
        end else if (in_data == CSV_LF) begin
          emit   = 1'b1;
          kind_d = TOK_END_RECORD;
        end else if (in_data == CSV_CR) begin
          state_d = FIELD_START;
        end else begin
          emit    = 1'b1;
          kind_d  = TOK_CHAR;
          data_d  = in_data;
          state_d = UNQUOTED;
        end
      end
      UNQUOTED: begin
        if (in_data == DELIM) begin
          emit    = 1'b1;
          kind_d  = TOK_END_FIELD;
          state_d = FIELD_START;
        end else if (in_data == CSV_LF) begin
          emit    = 1'b1;
          kind_d  = TOK_END_RECORD;
          state_d = FIELD_START;
        end else if (in_data == CSV_CR) begin
          state_d = UNQUOTED;
        end else if (in_data == QUOTE) begin
          // A quote inside an unquoted field is malformed.
          syntax_err = 1'b1;
        end else begin
          emit   = 1'b1;
          kind_d = TOK_CHAR;
          data_d = in_data;
        end
      end
      QUOTED: begin
        if (in_data == QUOTE) begin
          state_d = QUOTE_SEEN;
        end else begin
          // Separators and line endings are literal inside quotes.
          emit   = 1'b1;
          kind_d = TOK_CHAR;
          data_d = in_data;
        end
      end
      QUOTE_SEEN: begin
        if (in_data == QUOTE) begin
          // Doubled quote is an escaped literal quote.
          emit    = 1'b1;
          kind_d  = TOK_CHAR;
          data_d  = QUOTE;
          state_d = QUOTED;
        end else if (in_data == DELIM) begin
          emit    = 1'b1;
          kind_d  = TOK_END_FIELD;
          state_d = FIELD_START;
        end else if (in_data == CSV_LF) begin
          emit    = 1'b1;
          kind_d  = TOK_END_RECORD;
          state_d = FIELD_START;
        end else if (in_data == CSV_CR) begin
          state_d = QUOTE_SEEN;
        end else begin
          syntax_err = 1'b1;
        end
      end
      RESYNC: begin
        // Skip the rest of a broken record; the newline still closes it.
        if (in_data == CSV_LF) begin
          emit    = 1'b1;
          kind_d  = TOK_END_RECORD;
          state_d = FIELD_START;
        end
      end
      default: begin
        state_d = FIELD_START;
      end
    endcase
    if (syntax_err) begin
      state_d = RESYNC;
    end
  end

  // Parser state register; moves only on an accepted byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FIELD_START;
    end else if (accept) begin
      state_q <= state_d;
    end
  end

  // Single output register: load on a token-producing byte, clear on drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_kind_q  <= TOK_CHAR;
      out_data_q  <= 8'h00;
    end else if (accept && emit) begin
      out_valid_q <= 1'b1;
      out_kind_q  <= kind_d;
      out_data_q  <= data_d;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky error flag and saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      err_count_q <= 16'h0000;
    end else if (accept && syntax_err) begin
      err_q <= 1'b1;
      if (err_count_q != CSV_ERR_MAX) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

endmodule
